// File: rtl/lcd_bus_driver_pkg.sv
// Shared types and helpers for the HD44780-style LCD bus driver.
// Covers state encoding, word layout and the long-execution command decode.
package lcd_bus_driver_pkg;

  localparam int unsigned WordW = 9;
  localparam int unsigned RsBit = 8;

  localparam logic [7:0] CmdClear = 8'h01;
  localparam logic [7:0] CmdHome  = 8'h02;

  typedef enum logic [2:0] {
    StPwrup,
    StIdle,
    StSetup,
    StEpulse,
    StHold,
    StExec
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Clear (0x01) and home (0x02/0x03) are the only commands whose upper six bits are all zero,
  // apart from 0x00, which is deliberately treated as a normal command.
  function automatic logic is_long_exec(input logic [WordW-1:0] word);
    return !word[RsBit] && (word[7:0] != 8'h00) &&
           ((word[7:0] | (CmdClear | CmdHome)) == (CmdClear | CmdHome));
  endfunction

endpackage

// File: rtl/lcd_bus_driver_timer.sv
// Elapsed-cycle counter shared by every timed state of the LCD bus driver.
// Clears on a state change, saturates at all-ones and flags the last cycle of a limit.
module lcd_bus_driver_timer #(
  parameter int unsigned CntW = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic [CntW-1:0] limit_i,
  output logic            done_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The cycle holding count limit-1 is the last one of the state.
  assign done_o = (cnt_q == (limit_i - CntW'(1)));

endmodule

// File: rtl/lcd_bus_driver.sv
// Sink of the 9-bit {rs,byte} LCD symbol stream; drives an HD44780 8-bit write-only bus
// with power-up delay, setup, enable pulse, hold and command execution timing in cycles.
module lcd_bus_driver
  import lcd_bus_driver_pkg::*;
#(
  parameter int unsigned PWRUP_CYC     = 1_600_000,
  parameter int unsigned SETUP_CYC     = 5,
  parameter int unsigned EN_CYC        = 25,
  parameter int unsigned HOLD_CYC      = 2,
  parameter int unsigned EXEC_CYC      = 4_000,
  parameter int unsigned EXEC_LONG_CYC = 160_000
) (
  input  logic             clk_i,
  input  logic             rest_i,
  input  logic [WordW-1:0] data_i,
  input  logic             data_valid_i,
  output logic             ready_o,
  output logic             lcd_rs_o,
  output logic             lcd_rw_o,
  output logic             lcd_e_o,
  output logic [7:0]       lcd_db_o,
  output logic             busy_o
);

  localparam int unsigned MaxCyc = max_u(max_u(max_u(PWRUP_CYC, SETUP_CYC), max_u(EN_CYC, HOLD_CYC)),
                                         max_u(EXEC_CYC, EXEC_LONG_CYC));
  localparam int unsigned CntW   = $clog2(MaxCyc) + 1;

  state_e          state_q, state_d;
  logic            rs_q, rs_d;
  logic [7:0]      db_q, db_d;
  logic            long_q, long_d;
  logic            e_q, e_d;
  logic [CntW-1:0] limit;
  logic            done;

  always_comb begin
    state_d = state_q;
    rs_d    = rs_q;
    db_d    = db_q;
    long_d  = long_q;
    limit   = CntW'(1);
    unique case (state_q)
      StPwrup: begin
        limit = CntW'(PWRUP_CYC);
        if (done) state_d = StIdle;
      end
      StIdle: begin
        if (data_valid_i) begin
          rs_d    = data_i[RsBit];
          db_d    = data_i[7:0];
          long_d  = is_long_exec(data_i);
          state_d = StSetup;
        end
      end
      StSetup: begin
        limit = CntW'(SETUP_CYC);
        if (done) state_d = StEpulse;
      end
      StEpulse: begin
        limit = CntW'(EN_CYC);
        if (done) state_d = StHold;
      end
      StHold: begin
        limit = CntW'(HOLD_CYC);
        if (done) state_d = StExec;
      end
      StExec: begin
        limit = long_q ? CntW'(EXEC_LONG_CYC) : CntW'(EXEC_CYC);
        if (done) state_d = StIdle;
      end
      default: state_d = StPwrup;
    endcase
    // E is registered from the next state so the pin never glitches.
    e_d = (state_d == StEpulse);
  end

  always_ff @(posedge clk_i or posedge rest_i) begin
    if (rest_i) begin
      state_q <= StPwrup;
      rs_q    <= 1'b0;
      db_q    <= 8'h00;
      long_q  <= 1'b0;
      e_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      rs_q    <= rs_d;
      db_q    <= db_d;
      long_q  <= long_d;
      e_q     <= e_d;
    end
  end

  lcd_bus_driver_timer #(
    .CntW (CntW)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rest_i),
    .clr_i   (state_d != state_q),
    .limit_i (limit),
    .done_o  (done)
  );

  assign ready_o  = (state_q == StIdle);
  assign busy_o   = (state_q != StIdle);
  assign lcd_rw_o = 1'b0;
  assign lcd_e_o  = e_q;
  assign lcd_rs_o = rs_q;
  assign lcd_db_o = db_q;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Self-checking bench for lcd_bus_driver: fixed vectors, random words against a latency model,
// streaming, reset during the enable pulse, and a bus scoreboard checked on every E rise.
module tb_lcd_bus_driver;

  localparam int unsigned TPwrup = 20;
  localparam int unsigned TSetup = 2;
  localparam int unsigned TEn    = 4;
  localparam int unsigned THold  = 2;
  localparam int unsigned TExec  = 10;
  localparam int unsigned TLong  = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] data = 9'h000;
  logic       valid = 1'b0;
  logic       ready, lcd_rs, lcd_rw, lcd_e, busy;
  logic [7:0] lcd_db;

  always #5 clk = ~clk;

  lcd_bus_driver #(
    .PWRUP_CYC     (TPwrup),
    .SETUP_CYC     (TSetup),
    .EN_CYC        (TEn),
    .HOLD_CYC      (THold),
    .EXEC_CYC      (TExec),
    .EXEC_LONG_CYC (TLong)
  ) dut (
    .clk_i        (clk),
    .rest_i       (rst),
    .data_i       (data),
    .data_valid_i (valid),
    .ready_o      (ready),
    .lcd_rs_o     (lcd_rs),
    .lcd_rw_o     (lcd_rw),
    .lcd_e_o      (lcd_e),
    .lcd_db_o     (lcd_db),
    .busy_o       (busy)
  );

  int checks = 0;
  int errors = 0;
  int e_rises = 0;
  int rw_bad = 0;
  logic [8:0] sb_q[$];
  logic [8:0] mon_w;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: every accepted word appears on the bus exactly once, in order.
  always begin
    @(posedge lcd_e);
    e_rises++;
    if (sb_q.size() == 0) begin
      check("e_pulse_unexpected", 32'd1, 32'd0);
    end else begin
      mon_w = sb_q.pop_front();
      check("bus_word", {23'd0, lcd_rs, lcd_db}, {23'd0, mon_w});
    end
  end

  always @(negedge clk) if (lcd_rw !== 1'b0) rw_bad++;

  function automatic int model_latency(input logic [8:0] w);
    bit is_long;
    is_long = (w[8] == 1'b0) && (w[7:0] inside {8'h01, 8'h02, 8'h03});
    return TSetup + TEn + THold + (is_long ? TLong : TExec);
  endfunction

  // Called at a negedge; returns at the negedge where ready is back high.
  task automatic xfer(input logic [8:0] w, input int exp_lat, input bit keep_valid,
                      output int wait_cyc);
    int k, e_hi, first_e, bad, rises0;
    bit seen_ready;
    data = w;
    valid = 1'b1;
    wait_cyc = 0;
    while (!ready && wait_cyc < 200) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (!ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      valid = 1'b0;
      return;
    end
    sb_q.push_back(w);
    rises0 = e_rises;
    @(posedge clk);
    #1;
    if (!keep_valid) valid = 1'b0;
    e_hi = 0; first_e = -1; bad = 0; seen_ready = 1'b0;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if ({lcd_rs, lcd_db} !== w) bad++;
      if (busy !== !ready) bad++;
      if (lcd_e === 1'b1) begin
        e_hi++;
        if (first_e < 0) first_e = k;
      end
      if (ready === 1'b1) begin
        seen_ready = 1'b1;
        break;
      end
    end
    check("latency", k, exp_lat);
    check("e_width", e_hi, TEn);
    check("e_setup", first_e, TSetup);
    check("e_pulses_per_word", e_rises - rises0, 1);
    check("bus_stable", bad, 0);
    check("ready_returned", {31'd0, seen_ready}, 32'd1);
  endtask

  typedef struct {
    logic [8:0] word;
    int         lat;
  } vec_t;

  vec_t vecs[9];
  int wt, pre;
  logic [8:0] rw_word;

  initial begin
    vecs[0] = '{9'h141, 18};
    vecs[1] = '{9'h001, 38};
    vecs[2] = '{9'h038, 18};
    vecs[3] = '{9'h002, 38};
    vecs[4] = '{9'h003, 38};
    vecs[5] = '{9'h000, 18};
    vecs[6] = '{9'h004, 18};
    vecs[7] = '{9'h101, 18};
    vecs[8] = '{9'h0FF, 18};

    // Reset state, with valid already asserted.
    data = 9'h155;
    valid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_e", {31'd0, lcd_e}, 32'd0);
    check("rst_rs_db", {23'd0, lcd_rs, lcd_db}, 32'd0);

    rst = 1'b0;
    pre = e_rises;
    xfer(9'h155, model_latency(9'h155), 1'b0, wt);
    check("pwrup_wait", wt, TPwrup);
    check("pwrup_one_pulse", e_rises - pre, 1);

    foreach (vecs[i]) begin
      xfer(vecs[i].word, vecs[i].lat, 1'b0, wt);
      check("vec_no_wait", wt, 0);
      @(negedge clk);
    end

    // Valid low one cycle in IDLE, then a single command word; bus holds afterwards.
    valid = 1'b0;
    @(negedge clk);
    pre = e_rises;
    xfer(9'h080, model_latency(9'h080), 1'b0, wt);
    repeat (6) @(negedge clk);
    check("idle_hold_bus", {23'd0, lcd_rs, lcd_db}, 32'h080);
    check("idle_single_pulse", e_rises - pre, 1);

    // Streaming with valid never dropped.
    pre = e_rises;
    for (int i = 0; i < 8; i++) begin
      rw_word = 9'($urandom);
      xfer(rw_word, model_latency(rw_word), 1'b1, wt);
    end
    valid = 1'b0;
    repeat (4) @(negedge clk);
    check("stream_pulses", e_rises - pre, 8);

    // Random words, biased toward the clear/home commands.
    for (int i = 0; i < 24; i++) begin
      rw_word = 9'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        rw_word[8] = 1'b0;
        rw_word[7:2] = 6'd0;
      end
      xfer(rw_word, model_latency(rw_word), 1'b0, wt);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Reset during the enable pulse.
    data = 9'h1A5;
    valid = 1'b1;
    sb_q.push_back(9'h1A5);
    @(posedge clk);
    #1;
    valid = 1'b0;
    repeat (3) @(negedge clk);
    check("e_high_before_reset", {31'd0, lcd_e}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_e_drop", {31'd0, lcd_e}, 32'd0);
    check("async_ready_low", {31'd0, ready}, 32'd0);
    check("async_busy", {31'd0, busy}, 32'd1);
    check("async_bus_clear", {23'd0, lcd_rs, lcd_db}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    xfer(9'h0C3, model_latency(9'h0C3), 1'b0, wt);
    check("repwrup_wait", wt, TPwrup);

    repeat (4) @(negedge clk);
    check("rw_always_low", rw_bad, 0);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
